// File: rtl/rf_ctrl_pkg.sv
// Shared constants and types for the register-file access controller.
// Default geometry is the 32x32 RegFile; x0 is hardwired to zero by convention.
package rf_ctrl_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;
  localparam int RF_DEPTH  = 32;

  localparam logic [RF_ADDR_W-1:0] X0_ADDR = '0;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Pointer width for 2..4 requesters.
  function automatic int ptr_width(input int num_req);
    return (num_req > 2) ? 2 : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest-index valid requester at or after
// the pointer, and reports the pointer value that should follow the grant.
module rr_arbiter
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   next_ptr
);

  int   idx;
  logic found;

  // Scan starting at the pointer; the first hit wins and the pointer moves past it.
  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    idx      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (!found && valid[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        next_ptr   = PTR_W'((idx + 1) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Arbitrating front-end for the single-slot 32x32 RegFile.
// Define RFCTRL_INIT_SWEEP_EN to zero every register after each reset.
module regfile_access_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = RF_ADDR_W,
  parameter int DATA_W  = RF_DATA_W,
  parameter int DEPTH   = RF_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rs1,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rs2,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata1,
  output logic [DATA_W-1:0]         rsp_rdata2,
  output logic                      init_done,
  output logic                      rf_en,
  output logic                      rf_readEn,
  output logic                      rf_writeEn,
  output logic [ADDR_W-1:0]         rf_rs1,
  output logic [ADDR_W-1:0]         rf_rs2,
  output logic [ADDR_W-1:0]         rf_rd,
  output logic [DATA_W-1:0]         rf_dataIn,
  input  logic [DATA_W-1:0]         rf_readOut1,
  input  logic [DATA_W-1:0]         rf_readOut2
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic                accepting;
  logic                sweep_we;
  logic [ADDR_W-1:0]   sweep_rd;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    next_ptr;
  logic [NUM_REQ-1:0]  arb_valid;
  logic [NUM_REQ-1:0]  grant;
  logic                granted;
  logic                write_grant;
  logic                read_grant;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_rs1;
  logic [ADDR_W-1:0]   sel_rs2;
  logic [ADDR_W-1:0]   sel_rd;
  logic [DATA_W-1:0]   sel_wdata;

`ifdef RFCTRL_INIT_SWEEP_EN
  state_t            state;
  logic [ADDR_W-1:0] sweep_cnt;

  // Zero sweep: one register per cycle, then hand the slot to the requesters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (sweep_cnt == ADDR_W'(DEPTH - 1))
        state <= ST_RUN;
    end
  end

  assign accepting = reset && (state == ST_RUN);
  assign sweep_we  = reset && (state == ST_INIT);
  assign sweep_rd  = sweep_we ? sweep_cnt : '0;
`else
  assign accepting = reset;
  assign sweep_we  = 1'b0;
  assign sweep_rd  = '0;
`endif

  assign init_done = accepting;
  assign rf_en     = reset;
  assign arb_valid = accepting ? req_valid : '0;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_arbiter (
    .valid    (arb_valid),
    .ptr      (ptr),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  assign req_ready = grant;
  assign granted   = |grant;

  always_comb begin
    sel_we    = 1'b0;
    sel_rs1   = '0;
    sel_rs2   = '0;
    sel_rd    = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_we    = req_we[i];
        sel_rs1   = req_rs1[i*ADDR_W +: ADDR_W];
        sel_rs2   = req_rs2[i*ADDR_W +: ADDR_W];
        sel_rd    = req_rd[i*ADDR_W +: ADDR_W];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Writes to x0 are acknowledged but never reach the RegFile.
  assign write_grant = granted && sel_we && (sel_rd != ADDR_W'(X0_ADDR));
  assign read_grant  = granted && !sel_we;

  assign rf_writeEn = sweep_we | write_grant;
  assign rf_readEn  = read_grant;
  assign rf_rs1     = read_grant ? sel_rs1 : '0;
  assign rf_rs2     = read_grant ? sel_rs2 : '0;
  assign rf_rd      = sweep_we ? sweep_rd : (write_grant ? sel_rd : '0);
  assign rf_dataIn  = write_grant ? sel_wdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      ptr <= '0;
    else
      ptr <= next_ptr;
  end

  // Read data is captured at the grant edge and presented for exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid  <= '0;
      rsp_rdata1 <= '0;
      rsp_rdata2 <= '0;
    end else begin
      rsp_valid <= read_grant ? grant : '0;
      if (read_grant) begin
        rsp_rdata1 <= rf_readOut1;
        rsp_rdata2 <= rf_readOut2;
      end
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench for regfile_access_ctrl with a behavioural RegFile model.
// Covers reset, zero sweep (RFCTRL_INIT_SWEEP_EN), arbitration, x0 writes, reset mid-read.
module tb_regfile_access_ctrl;

  localparam int NR = 2;
  localparam int AW = 5;
  localparam int DW = 32;

`ifdef RFCTRL_INIT_SWEEP_EN
  localparam logic [31:0] INIT_FILL = 32'hA5A5_A5A5;
  localparam logic [31:0] R3_EXP    = 32'h0000_0000;
`else
  localparam logic [31:0] INIT_FILL = 32'h0000_0000;
  localparam logic [31:0] R3_EXP    = 32'hCAFE_F00D;
`endif

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [NR-1:0]       req_valid, req_ready, req_we, rsp_valid;
  logic [NR*AW-1:0]    req_rs1, req_rs2, req_rd;
  logic [NR*DW-1:0]    req_wdata;
  logic [DW-1:0]       rsp_rdata1, rsp_rdata2, rf_dataIn, rf_readOut1, rf_readOut2;
  logic                init_done, rf_en, rf_readEn, rf_writeEn;
  logic [AW-1:0]       rf_rs1, rf_rs2, rf_rd;
  logic [DW-1:0]       regs [32];

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [1:0]  valid;
    logic [1:0]  we;
    logic [4:0]  a0, a1, b0, b1;
    logic [31:0] d0, d1;
    logic [1:0]  exp_ready;
    logic        exp_we;
    logic        exp_re;
    logic [1:0]  exp_rsp;
    logic [31:0] exp_q1, exp_q2;
  } vec_t;

  vec_t vecs [12];
  vec_t idle_vec, busy_vec, wr3_vec, rd3_vec;

  always #5 clk = ~clk;

  regfile_access_ctrl #(.NUM_REQ(NR)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_rd      (req_rd),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_rdata1  (rsp_rdata1),
    .rsp_rdata2  (rsp_rdata2),
    .init_done   (init_done),
    .rf_en       (rf_en),
    .rf_readEn   (rf_readEn),
    .rf_writeEn  (rf_writeEn),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .rf_rd       (rf_rd),
    .rf_dataIn   (rf_dataIn),
    .rf_readOut1 (rf_readOut1),
    .rf_readOut2 (rf_readOut2)
  );

  // RegFile model: synchronous write, combinational read.
  always @(posedge clk)
    if (rf_en && rf_writeEn)
      regs[rf_rd] <= rf_dataIn;

  assign rf_readOut1 = rf_readEn ? regs[rf_rs1] : '0;
  assign rf_readOut2 = rf_readEn ? regs[rf_rs2] : '0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    req_valid = v.valid;
    req_we    = v.we;
    req_rs1   = {v.a1, v.a0};
    req_rd    = {v.a1, v.a0};
    req_rs2   = {v.b1, v.b0};
    req_wdata = {v.d1, v.d0};
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 32; i++) regs[i] <= INIT_FILL;

    //           valid  we     a0    a1    b0    b1    d0            d1            rdy    we    re    rsp    q1            q2
    vecs[0]  = '{2'b01, 2'b01, 5'd5, 5'd0, 5'd0, 5'd0, 32'hDEADBEEF, 32'h0,        2'b01, 1'b1, 1'b0, 2'b00, 32'h0,        32'h0};
    vecs[1]  = '{2'b01, 2'b00, 5'd5, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b01, 1'b0, 1'b1, 2'b01, 32'hDEADBEEF, 32'h0};
    vecs[2]  = '{2'b10, 2'b10, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h12345678, 2'b10, 1'b0, 1'b0, 2'b00, 32'hDEADBEEF, 32'h0};
    vecs[3]  = '{2'b11, 2'b00, 5'd0, 5'd5, 5'd5, 5'd0, 32'h0,        32'h0,        2'b01, 1'b0, 1'b1, 2'b01, 32'h0,        32'hDEADBEEF};
    vecs[4]  = '{2'b11, 2'b00, 5'd0, 5'd5, 5'd5, 5'd0, 32'h0,        32'h0,        2'b10, 1'b0, 1'b1, 2'b10, 32'hDEADBEEF, 32'h0};
    vecs[5]  = '{2'b11, 2'b00, 5'd0, 5'd5, 5'd5, 5'd0, 32'h0,        32'h0,        2'b01, 1'b0, 1'b1, 2'b01, 32'h0,        32'hDEADBEEF};
    vecs[6]  = '{2'b11, 2'b11, 5'd7, 5'd9, 5'd0, 5'd0, 32'h11111111, 32'h22222222, 2'b10, 1'b1, 1'b0, 2'b00, 32'h0,        32'hDEADBEEF};
    vecs[7]  = '{2'b11, 2'b01, 5'd7, 5'd9, 5'd0, 5'd7, 32'h11111111, 32'h0,        2'b01, 1'b1, 1'b0, 2'b00, 32'h0,        32'hDEADBEEF};
    vecs[8]  = '{2'b10, 2'b00, 5'd7, 5'd9, 5'd0, 5'd7, 32'h0,        32'h0,        2'b10, 1'b0, 1'b1, 2'b10, 32'h22222222, 32'h11111111};
    vecs[9]  = '{2'b00, 2'b00, 5'd0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00, 1'b0, 1'b0, 2'b00, 32'h22222222, 32'h11111111};
    vecs[10] = '{2'b10, 2'b00, 5'd0, 5'd0, 5'd0, 5'd9, 32'h0,        32'h0,        2'b10, 1'b0, 1'b1, 2'b10, 32'h0,        32'h22222222};
    vecs[11] = '{2'b11, 2'b00, 5'd7, 5'd0, 5'd7, 5'd0, 32'h0,        32'h0,        2'b01, 1'b0, 1'b1, 2'b01, 32'h11111111, 32'h11111111};

    idle_vec = '0;
    busy_vec = '0;
    busy_vec.valid = 2'b11;
    wr3_vec = '0;
    wr3_vec.valid = 2'b01;
    wr3_vec.we    = 2'b01;
    wr3_vec.a0    = 5'd3;
    wr3_vec.d0    = 32'hCAFEF00D;
    rd3_vec = '0;
    rd3_vec.valid = 2'b01;
    rd3_vec.a0    = 5'd3;

    // Reset held with both requesters asking.
    applyStimulus(busy_vec);
    @(posedge clk); #1;
    checkOutput("rst_ready",     32'(req_ready), 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rdata1",    rsp_rdata1,     32'h0);
    checkOutput("rst_rdata2",    rsp_rdata2,     32'h0);
    checkOutput("rst_init_done", 32'(init_done), 32'h0);
    checkOutput("rst_rf_en",     32'(rf_en),     32'h0);
    checkOutput("rst_writeEn",   32'(rf_writeEn), 32'h0);
    checkOutput("rst_readEn",    32'(rf_readEn), 32'h0);

`ifdef RFCTRL_INIT_SWEEP_EN
    reset = 1'b1; #1;
    for (int c = 0; c < 17; c++) begin
      checkOutput($sformatf("sweep_a_rd%0d", c), 32'(rf_rd), 32'(c));
      @(posedge clk); #1;
    end
    checkOutput("sweep_a_rd17", 32'(rf_rd), 32'd17);
    reset = 1'b0; #1;
    checkOutput("midsweep_writeEn",   32'(rf_writeEn), 32'h0);
    checkOutput("midsweep_rd",        32'(rf_rd),      32'h0);
    checkOutput("midsweep_rf_en",     32'(rf_en),      32'h0);
    checkOutput("midsweep_init_done", 32'(init_done),  32'h0);
    @(posedge clk); #1;
    reset = 1'b1; #1;
    for (int c = 0; c < 32; c++) begin
      checkOutput($sformatf("sweep_we%0d", c),    32'(rf_writeEn), 32'h1);
      checkOutput($sformatf("sweep_rd%0d", c),    32'(rf_rd),      32'(c));
      checkOutput($sformatf("sweep_data%0d", c),  rf_dataIn,       32'h0);
      checkOutput($sformatf("sweep_ready%0d", c), 32'(req_ready),  32'h0);
      checkOutput($sformatf("sweep_done%0d", c),  32'(init_done),  32'h0);
      @(posedge clk); #1;
    end
    checkOutput("init_done_rise", 32'(init_done), 32'h1);
`else
    applyStimulus(wr3_vec);
    reset = 1'b1; #1;
    checkOutput("nosweep_init_done", 32'(init_done),  32'h1);
    checkOutput("nosweep_ready",     32'(req_ready),  32'h1);
    checkOutput("nosweep_writeEn",   32'(rf_writeEn), 32'h1);
    checkOutput("nosweep_rd",        32'(rf_rd),      32'h3);
    @(posedge clk); #1;
`endif

    // Read outstanding when reset hits: the response must vanish.
    applyStimulus(rd3_vec); #1;
    checkOutput("midread_grant",  32'(req_ready), 32'h1);
    checkOutput("midread_readEn", 32'(rf_readEn), 32'h1);
    @(posedge clk); #1;
    checkOutput("midread_rsp",    32'(rsp_valid), 32'h1);
    checkOutput("midread_data",   rsp_rdata1,     R3_EXP);
    applyStimulus(idle_vec);
    reset = 1'b0; #1;
    checkOutput("midread_rst_rsp",   32'(rsp_valid), 32'h0);
    checkOutput("midread_rst_data",  rsp_rdata1,     32'h0);
    checkOutput("midread_rst_rf_en", 32'(rf_en),     32'h0);
    @(posedge clk); #1;
    reset = 1'b1; #1;
    for (int i = 0; i < 40 && init_done !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("init_wait",        32'(init_done), 32'h1);
    checkOutput("post_rst_rsp",     32'(rsp_valid), 32'h0);

    // Arbitration, write-then-read, x0 protection and data hold.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]); #1;
      checkOutput($sformatf("v%0d_ready", i),   32'(req_ready),  32'(vecs[i].exp_ready));
      checkOutput($sformatf("v%0d_writeEn", i), 32'(rf_writeEn), 32'(vecs[i].exp_we));
      checkOutput($sformatf("v%0d_readEn", i),  32'(rf_readEn),  32'(vecs[i].exp_re));
      if (vecs[i].exp_ready == 2'b00)
        checkOutput($sformatf("v%0d_idle_bus", i),
                    32'(rf_rs1) | 32'(rf_rs2) | 32'(rf_rd) | rf_dataIn, 32'h0);
      @(posedge clk); #1;
      checkOutput($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].exp_rsp));
      checkOutput($sformatf("v%0d_rdata1", i),    rsp_rdata1,     vecs[i].exp_q1);
      checkOutput($sformatf("v%0d_rdata2", i),    rsp_rdata2,     vecs[i].exp_q2);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/regfile_access_ctrl.md
# regfile_access_ctrl

Sequencing and arbitration front-end for the 32x32 register file. Shares the RegFile's single access slot (two read ports, one write port, one operation per cycle) among NUM_REQ requesters with round-robin valid/ready arbitration, returns read data one cycle after grant, and optionally zero-initialises every register after reset. Sits between the datapath/debug requesters and the RegFile instance.

## Interface
- NUM_REQ, 2, number of requesters (2..4)
- ADDR_W, 5, register address width
- DATA_W, 32, data width
- DEPTH, 32, number of registers (2**ADDR_W)

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  request pending, one bit per requester
- req_ready  out  NUM_REQ  one-hot grant; transfer when valid&&ready
- req_we  in  NUM_REQ  1 = write, 0 = read
- req_rs1, req_rs2, req_rd  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*DATA_W  packed write data
- rsp_valid  out  NUM_REQ  one-hot, read data valid for that requester
- rsp_rdata1, rsp_rdata2  out  DATA_W  registered read data
- init_done  out  1  high once the controller accepts requests
- rf_en, rf_readEn, rf_writeEn  out  1  RegFile controls
- rf_rs1, rf_rs2, rf_rd  out  ADDR_W  RegFile addresses
- rf_dataIn  out  DATA_W  RegFile write data
- rf_readOut1, rf_readOut2  in  DATA_W  RegFile read data, combinational from rf_rs1/rf_rs2 while rf_readEn=1

## Operation
- States: INIT (zero sweep), RUN. Reset enters INIT (macro on) or RUN (macro off).
- INIT: sweep counter 0..DEPTH-1; each cycle rf_writeEn=1, rf_rd=counter, rf_dataIn=0; req_ready=0. After writing DEPTH-1, next state RUN; init_done=1 from first RUN cycle.
- RUN: rr_arbiter grants lowest index at/after pointer among req_valid bits; at most one grant per cycle; req_ready combinational.
- Pointer: after a grant to i, pointer = (i+1) mod NUM_REQ; unchanged when no grant. Reset value 0.
- Granted write: rf_writeEn=1, rf_rd/rf_dataIn from requester. rd=0: granted and acknowledged, but rf_writeEn held 0 (x0 stays zero).
- Granted read: rf_readEn=1, rf_rs1/rf_rs2 from requester; rf_readOut1/2 captured into rsp_rdata1/2 at the same edge; rsp_valid[i]=1 for exactly the next cycle.
- Ungranted cycles: rf_readEn=rf_writeEn=0, addresses/data 0.
- Requester must hold fields stable while valid && !ready; controller never drops a held request (no starvation: worst-case wait NUM_REQ-1 grants).
- rsp_rdata1/2 hold last read value when rsp_valid=0.
- rf_en=1 whenever reset is deasserted, 0 while asserted.

## Timing
- Reset values: state per macro, pointer 0, sweep counter 0, rsp_valid 0, rsp_rdata1/2 0, init_done 0 (macro on) / 1 after reset release (macro off); all rf_* outputs 0.
- Read latency: grant in cycle N, rsp_valid and data in cycle N+1.
- Write commits at end of grant cycle; read granted in cycle N+1 to same address returns new data (no forwarding needed).
- Back-to-back grants every cycle supported; reads may issue every cycle.
- Reset mid-sweep or mid-read: pending response discarded, sweep restarts at 0.
- Sweep length: DEPTH cycles; init_done rises DEPTH cycles after reset release.

## Configuration
- RFCTRL_INIT_SWEEP_EN defined: INIT state and sweep counter present, register file zeroed after every reset.
- Undefined: no INIT state or counter; controller starts in RUN, init_done=1 from first cycle after reset release; register contents unspecified until written.

## Structure
- Package rf_ctrl_pkg: ADDR_W, DATA_W, DEPTH constants; state enum (INIT, RUN); x0 address constant.
- Sub-module rr_arbiter: NUM_REQ-wide round-robin grant from valid vector and pointer, outputs one-hot grant and next pointer.

## Test plan
- Reset release with macro on -> 32 cycles of rf_writeEn=1, rf_rd 0..31, rf_dataIn=0; init_done=1 at cycle 33; req_ready=0 throughout.
- Req0 writes 0xDEADBEEF to r5, next cycle req0 reads rs1=5, rs2=0 -> rsp_valid=01 one cycle later, rsp_rdata1=0xDEADBEEF, rsp_rdata2=0.
- Both requesters valid continuously with reads -> grants alternate 01,10,01,...; each rsp_valid one cycle after its grant.
- Req1 writes 0x12345678 to r0 -> req_ready[1]=1, rf_writeEn stays 0; later read of r0 returns 0.
- Reset asserted mid-sweep at counter 17 -> all outputs 0 immediately; after release sweep restarts at rd=0.
- Macro off -> init_done=1 first cycle after release; req0 write granted same cycle.
